bus_resp: RTL
=============

BUS_RESP -- requirements
Module: bus_resp

Interface
REQ-001 clk  input  1  clock; all state changes on rising edge.
REQ-002 RST  input  1  reset; synchronous, active-high.
REQ-003 AB  input  16  CPU address bus; held stable by CPU while RDY=0.
REQ-004 WE  input  1  CPU write strobe for current cycle.
REQ-005 DO  input  8  CPU write data.
REQ-006 DB  output  8  registered read data returned to CPU.
REQ-007 RDY  output  1  combinational; 0 stalls CPU, which holds AB/WE/DO.
REQ-008 ext_req  output  1  registered external request.
REQ-009 ext_we  output  1  external write flag, valid with ext_req.
REQ-010 ext_addr  output  15  external address, AB[14:0] of latched access.
REQ-011 ext_wdata  output  8  external write data.
REQ-012 ext_ack  input  1  external completion, single cycle.
REQ-013 ext_rdata  input  8  external read data, valid with ext_ack.
REQ-014 err  output  1  sticky timeout flag.
REQ-015 TIMEOUT parameter, default 255, meaning max REQ cycles before abort (1..255).

Function
REQ-016 Decode: RAM region 0x0000-0x01FF (internal 512x8 array); SLOW region 0x8000-0xFFFF (external handshake); all other addresses are NULL.
REQ-017 An access completes on any rising edge where RDY=1; DB is updated only on completing edges and holds otherwise.
REQ-018 RAM read completing at edge n: DB = RAM[AB[8:0]] from edge n, zero wait states.
REQ-019 RAM write completing at edge n: RAM[AB[8:0]] <= DO; DB <= old contents (read-before-write); a read of the same address at edge n+1 returns DO.
REQ-020 NULL access: zero wait states; read sets DB=0xFF; write ignored, DB=0xFF.
REQ-021 FSM states IDLE, REQ, DONE; reset state IDLE.
REQ-022 IDLE with SLOW hit: RDY=0; latch AB[14:0], WE, DO into ext_addr/ext_we/ext_wdata; next state REQ; wait counter cleared.
REQ-023 IDLE with RAM/NULL hit: RDY=1; state stays IDLE.
REQ-024 REQ: ext_req=1, RDY=0; ext_ack=1 -> capture ext_rdata (reads only), next DONE; else counter increments.
REQ-025 REQ with counter reaching TIMEOUT and no ack: abort, captured data = 0xFF, err <= 1, next DONE; write not retried.
REQ-026 ext_ack=1 on the same edge as timeout: ack wins, err unchanged.
REQ-027 DONE: ext_req=0, RDY=1, access completes; DB <= captured data (reads) or 0xFF (writes); next IDLE; SLOW decode suppressed in DONE so held AB does not retrigger.
REQ-028 ext_ack outside REQ is ignored; ext_rdata sampled only on ext_ack in REQ.
REQ-029 Minimum SLOW access: 2 stall cycles (IDLE, REQ with immediate ack), completion in DONE.
REQ-030 ext_req, ext_addr, ext_we, ext_wdata are stable for the whole REQ period.
REQ-031 Back-to-back SLOW accesses: IDLE after DONE re-decodes new AB normally; no idle gap required beyond DONE.
REQ-032 err clears only on reset.

Reset
REQ-033 RST=1 at an edge: state IDLE, DB=0x00, ext_req=0, ext_we=0, ext_addr=0, ext_wdata=0, err=0, counter=0.
REQ-034 RST mid-REQ aborts the access: ext_req=0 next cycle, no DB update; a late ext_ack after reset is ignored.
REQ-035 RAM contents are not cleared by reset.
REQ-036 While RST=1, RDY=1 and no RAM write occurs.

Verification
REQ-037 Write 0x5A to 0x0123, read 0x0123 next cycle -> RDY stays 1; DB=0x5A one edge after read edge.
REQ-038 Read 0x8004, ext_ack with ext_rdata=0xC3 on first REQ cycle -> RDY low 2 cycles, ext_addr=0x0004, DB=0xC3 after DONE edge.
REQ-039 Write 0xFFFE data 0x77, ack after 10 REQ cycles -> ext_we=1, ext_wdata=0x77 stable 10 cycles, RDY low 11 cycles, err=0.
REQ-040 Read 0x9000, no ack -> abort after TIMEOUT REQ cycles, DB=0xFF, err=1 and stays 1.
REQ-041 Read 0x4000 -> no stall, DB=0xFF; write 0x0200 -> RAM unchanged.
REQ-042 RST during REQ, then ext_ack next cycle -> state IDLE, ext_req=0, DB=0x00, err=0, ack ignored.

Source files
------------

// File: rtl/bus_resp.sv
// bus_resp: CPU bus responder with an internal 512x8 RAM, a NULL region that
// reads as 0xFF, and a SLOW region served through an external req/ack
// handshake with a timeout abort.
//
// state | meaning
// IDLE  | decode AB; RAM/NULL finish this cycle, SLOW latches and stalls
// REQ   | ext_req high, waiting for ext_ack or timeout
// DONE  | SLOW access completes, DB gets captured data
module bus_resp #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] AB,
  input  logic        WE,
  input  logic [7:0]  DO,
  output logic [7:0]  DB,
  output logic        RDY,
  output logic        ext_req,
  output logic        ext_we,
  output logic [14:0] ext_addr,
  output logic [7:0]  ext_wdata,
  input  logic        ext_ack,
  input  logic [7:0]  ext_rdata,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  // Abort fires on the TIMEOUT-th REQ cycle, when the counter of elapsed
  // unacknowledged REQ cycles equals TIMEOUT-1.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cap_q, cap_d;
  logic [7:0]  db_q, db_d;
  logic        err_q, err_d;
  logic        ext_req_q, ext_req_d;
  logic        ext_we_q, ext_we_d;
  logic [14:0] ext_addr_q, ext_addr_d;
  logic [7:0]  ext_wdata_q, ext_wdata_d;
  logic        rdy;
  logic        ram_we;
  logic        ram_hit;
  logic        slow_hit;
  logic [7:0]  mem [512];

  assign ram_hit  = (AB[15:9] == 7'd0);
  assign slow_hit = AB[15];

  // Next-state, completion data and stall decision.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_d       = cap_q;
    db_d        = db_q;
    err_d       = err_q;
    ext_we_d    = ext_we_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    rdy         = 1'b1;
    ram_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (slow_hit) begin
          rdy         = 1'b0;
          ext_addr_d  = AB[14:0];
          ext_we_d    = WE;
          ext_wdata_d = DO;
          cnt_d       = 8'd0;
          state_d     = REQ;
        end else if (ram_hit) begin
          db_d   = mem[AB[8:0]];
          ram_we = WE;
        end else begin
          db_d = 8'hFF;
        end
      end
      REQ: begin
        rdy = 1'b0;
        if (ext_ack) begin
          if (!ext_we_q) cap_d = ext_rdata;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          cap_d   = 8'hFF;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        // AB still points at the SLOW address here; it is not re-decoded.
        db_d    = ext_we_q ? 8'hFF : cap_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ext_req_d = (state_d == REQ);
    if (RST) begin
      rdy    = 1'b1;
      ram_we = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      cap_q       <= 8'd0;
      db_q        <= 8'd0;
      err_q       <= 1'b0;
      ext_req_q   <= 1'b0;
      ext_we_q    <= 1'b0;
      ext_addr_q  <= 15'd0;
      ext_wdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      db_q        <= db_d;
      err_q       <= err_d;
      ext_req_q   <= ext_req_d;
      ext_we_q    <= ext_we_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem[AB[8:0]] <= DO;
  end

  assign DB        = db_q;
  assign RDY       = rdy;
  assign ext_req   = ext_req_q;
  assign ext_we    = ext_we_q;
  assign ext_addr  = ext_addr_q;
  assign ext_wdata = ext_wdata_q;
  assign err       = err_q;

endmodule
